// File: rtl/pipeline_status.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_status (package)
//  Description : Shared pipeline status encodings.
//                forwards_t   - status of an instruction travelling down the
//                               pipe.
//                backwards_t  - command broadcast back up the pipe.
//                trap_cause_t - machine-mode mcause exception codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_status;

    localparam int unsigned c_XLEN = 32;

    // Encodings 11..15 are unused and are treated as illegal instructions.
    typedef enum logic [3:0] {
        BUBBLE              = 4'd0,
        VALID               = 4'd1,
        FETCH_MISALIGNED    = 4'd2,
        FETCH_FAULT         = 4'd3,
        ILLEGAL_INSTRUCTION = 4'd4,
        EBREAK              = 4'd5,
        LOAD_MISALIGNED     = 4'd6,
        LOAD_FAULT          = 4'd7,
        STORE_MISALIGNED    = 4'd8,
        STORE_FAULT         = 4'd9,
        ECALL               = 4'd10
    } forwards_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;

    typedef enum logic [3:0] {
        CAUSE_FETCH_MISALIGNED    = 4'd0,
        CAUSE_FETCH_FAULT         = 4'd1,
        CAUSE_ILLEGAL_INSTRUCTION = 4'd2,
        CAUSE_EBREAK              = 4'd3,
        CAUSE_LOAD_MISALIGNED     = 4'd4,
        CAUSE_LOAD_FAULT          = 4'd5,
        CAUSE_STORE_MISALIGNED    = 4'd6,
        CAUSE_STORE_FAULT         = 4'd7,
        CAUSE_ECALL               = 4'd11
    } trap_cause_t;

endpackage : pipeline_status
`default_nettype wire

// File: rtl/trap_unit_cause_encode.sv
`default_nettype none
// ============================================================================
//  Module      : trap_cause_encode
//  Description : Combinational map from writeback status to mcause / mtval.
//  Ports       : status - writeback status (forwards_t)
//                pc     - PC of the writeback instruction
//                tval   - pipeline-supplied faulting address / bits
//                cause  - mcause exception code
//                mtval  - value destined for the mtval CSR
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_cause_encode
    import pipeline_status::*;
(
    input  forwards_t   status,
    input  logic [31:0] pc,
    input  logic [31:0] tval,
    output trap_cause_t cause,
    output logic [31:0] mtval
);

    always_comb begin
        cause = CAUSE_ILLEGAL_INSTRUCTION;
        mtval = tval;
        case (status)
            FETCH_MISALIGNED:    cause = CAUSE_FETCH_MISALIGNED;
            FETCH_FAULT:         cause = CAUSE_FETCH_FAULT;
            ILLEGAL_INSTRUCTION: cause = CAUSE_ILLEGAL_INSTRUCTION;
            EBREAK: begin
                cause = CAUSE_EBREAK;
                mtval = pc;          // breakpoint reports its own address
            end
            LOAD_MISALIGNED:     cause = CAUSE_LOAD_MISALIGNED;
            LOAD_FAULT:          cause = CAUSE_LOAD_FAULT;
            STORE_MISALIGNED:    cause = CAUSE_STORE_MISALIGNED;
            STORE_FAULT:         cause = CAUSE_STORE_FAULT;
            ECALL: begin
                cause = CAUSE_ECALL;
                mtval = 32'd0;       // environment call carries no value
            end
            // BUBBLE/VALID never reach capture; unused codes are illegal.
            default:             cause = CAUSE_ILLEGAL_INSTRUCTION;
        endcase
    end

endmodule : trap_cause_encode
`default_nettype wire

// File: rtl/trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : trap_unit
//  Description : Machine-mode trap/return sequencer at the writeback stage.
//                Captures exceptions into mepc/mcause/mtval, redirects fetch
//                to mtvec (trap) or mepc (MRET), and counts retirements.
//  Ports       : clk, reset   - clock, async active-high reset
//                wb_status    - status of instruction leaving writeback
//                wb_pc        - its PC
//                wb_tval      - faulting address / instruction bits
//                wb_mret      - instruction is MRET (with VALID only)
//                mtvec        - trap vector base
//                pipe_ctrl    - READY / STALL / JUMP broadcast
//                redirect_pc  - fetch target while JUMP, else 0
//                mepc, mcause, mtval - trap CSRs
//                minstret     - 64-bit retired-instruction counter
//                trap_taken   - one-cycle pulse on trap capture
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_unit
    import pipeline_status::*;
(
    input  logic        clk,
    input  logic        reset,
    input  forwards_t   wb_status,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_tval,
    input  logic        wb_mret,
    input  logic [31:0] mtvec,
    output backwards_t  pipe_ctrl,
    output logic [31:0] redirect_pc,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic [63:0] minstret,
    output logic        trap_taken
);

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_TRAP_JUMP = 2'd1;
    localparam logic [1:0] c_S_TRAP_HOLD = 2'd2;
    localparam logic [1:0] c_S_RET_JUMP  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_mepc;
    logic [3:0]  r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_minstret;
    logic        r_trap_taken;
    // Jump target is latched when the jump is decided so that redirect_pc
    // depends only on registered state.
    logic [31:0] r_target;

    trap_cause_t w_cause;
    logic [31:0] w_mtval;
    logic        w_unused_mtvec_lo;

    assign w_unused_mtvec_lo = ^mtvec[1:0];

    trap_cause_encode u_encode (
        .status (wb_status),
        .pc     (wb_pc),
        .tval   (wb_tval),
        .cause  (w_cause),
        .mtval  (w_mtval)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_mepc       <= 32'd0;
            r_mcause     <= 4'd0;
            r_mtval      <= 32'd0;
            r_minstret   <= 64'd0;
            r_trap_taken <= 1'b0;
            r_target     <= 32'd0;
        end else begin
            r_trap_taken <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (wb_status == VALID) begin
                        r_minstret <= r_minstret + 64'd1;
                        if (wb_mret) begin
                            r_state  <= c_S_RET_JUMP;
                            r_target <= r_mepc;
                        end
                    end else if (wb_status != BUBBLE) begin
                        r_state      <= c_S_TRAP_JUMP;
                        r_mepc       <= wb_pc;
                        r_mcause     <= w_cause;
                        r_mtval      <= w_mtval;
                        r_trap_taken <= 1'b1;
                        r_target     <= {mtvec[31:2], 2'b00};
                    end
                end
                c_S_TRAP_JUMP: r_state <= c_S_TRAP_HOLD;
                c_S_TRAP_HOLD: r_state <= c_S_IDLE;
                c_S_RET_JUMP:  r_state <= c_S_IDLE;
                default:       r_state <= c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_ctrl = READY;
        case (r_state)
            c_S_TRAP_JUMP: pipe_ctrl = JUMP;
            c_S_RET_JUMP:  pipe_ctrl = JUMP;
            c_S_TRAP_HOLD: pipe_ctrl = STALL;
            default:       pipe_ctrl = READY;
        endcase
    end

    assign redirect_pc = (pipe_ctrl == JUMP) ? r_target : 32'd0;
    assign mepc        = r_mepc;
    assign mcause      = {28'd0, r_mcause};
    assign mtval       = r_mtval;
    assign minstret    = r_minstret;
    assign trap_taken  = r_trap_taken;

endmodule : trap_unit
`default_nettype wire

// File: tb/tb_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_unit
//  Description : Directed self-checking bench for trap_unit. Each step drives
//                writeback inputs, queues the values expected after the next
//                rising edge, and pops/compares them once the edge has passed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_unit;
    import pipeline_status::*;

    logic        clk;
    logic        reset;
    forwards_t   wb_status;
    logic [31:0] wb_pc;
    logic [31:0] wb_tval;
    logic        wb_mret;
    logic [31:0] mtvec;
    backwards_t  pipe_ctrl;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] minstret;
    logic        trap_taken;

    trap_unit dut (
        .clk         (clk),
        .reset       (reset),
        .wb_status   (wb_status),
        .wb_pc       (wb_pc),
        .wb_tval     (wb_tval),
        .wb_mret     (wb_mret),
        .mtvec       (mtvec),
        .pipe_ctrl   (pipe_ctrl),
        .redirect_pc (redirect_pc),
        .mepc        (mepc),
        .mcause      (mcause),
        .mtval       (mtval),
        .minstret    (minstret),
        .trap_taken  (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        backwards_t  ctrl;
        logic [31:0] redir;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] tv;
        logic [63:0] instret;
        logic        tt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string tag, input string fld,
                       input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req)
        else begin
            n_err++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, req);
        end
    endtask

    task automatic expect_out(input string tag, input backwards_t ctrl,
                              input logic [31:0] redir, input logic [31:0] epc,
                              input logic [31:0] cause, input logic [31:0] tv,
                              input logic [63:0] instret, input logic tt);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.redir = redir; e.epc = epc;
        e.cause = cause; e.tv = tv; e.instret = instret; e.tt = tt;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbq.pop_front();
            cmp(e.tag, "pipe_ctrl",   64'(pipe_ctrl),   64'(e.ctrl));
            cmp(e.tag, "redirect_pc", 64'(redirect_pc), 64'(e.redir));
            cmp(e.tag, "mepc",        64'(mepc),        64'(e.epc));
            cmp(e.tag, "mcause",      64'(mcause),      64'(e.cause));
            cmp(e.tag, "mtval",       64'(mtval),       64'(e.tv));
            cmp(e.tag, "minstret",    minstret,         e.instret);
            cmp(e.tag, "trap_taken",  64'(trap_taken),  64'(e.tt));
        end
    endtask

    // Drive at the falling edge, expect the result one rising edge later.
    task automatic step(input string tag, input forwards_t st,
                        input logic [31:0] pc, input logic [31:0] tv_in,
                        input logic mret, input backwards_t ctrl,
                        input logic [31:0] redir, input logic [31:0] epc,
                        input logic [31:0] cause, input logic [31:0] tv,
                        input logic [63:0] instret, input logic tt);
        wb_status = st;
        wb_pc     = pc;
        wb_tval   = tv_in;
        wb_mret   = mret;
        expect_out(tag, ctrl, redir, epc, cause, tv, instret, tt);
        @(posedge clk);
        @(negedge clk);
        pop_check();
    endtask

    initial begin
        reset     = 1'b1;
        wb_status = BUBBLE;
        wb_pc     = 32'd0;
        wb_tval   = 32'd0;
        wb_mret   = 1'b0;
        mtvec     = 32'h0000_8001;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", READY, 0, 0, 0, 0, 0, 0);
        pop_check();
        reset = 1'b0;

        // Three retirements, READY throughout
        step("v100", VALID, 32'h100, 0, 0, READY, 0, 0, 0, 0, 1, 0);
        step("v104", VALID, 32'h104, 0, 0, READY, 0, 0, 0, 0, 2, 0);
        step("v108", VALID, 32'h108, 0, 0, READY, 0, 0, 0, 0, 3, 0);
        step("bub",  BUBBLE, 32'h10C, 0, 0, READY, 0, 0, 0, 0, 3, 0);

        // Load fault: JUMP to aligned mtvec, then STALL, then READY
        step("lf_jump", LOAD_FAULT, 32'h200, 32'hDEAD_0000, 0,
             JUMP, 32'h8000, 32'h200, 5, 32'hDEAD_0000, 3, 1);
        step("lf_hold", BUBBLE, 0, 0, 0, STALL, 0, 32'h200, 5, 32'hDEAD_0000, 3, 0);
        step("lf_idle", BUBBLE, 0, 0, 0, READY, 0, 32'h200, 5, 32'hDEAD_0000, 3, 0);

        // ECALL then MRET back to mepc
        step("ec_jump", ECALL, 32'h300, 32'h1234_5678, 0,
             JUMP, 32'h8000, 32'h300, 11, 0, 3, 1);
        step("ec_hold", BUBBLE, 0, 0, 0, STALL, 0, 32'h300, 11, 0, 3, 0);
        step("ec_idle", BUBBLE, 0, 0, 0, READY, 0, 32'h300, 11, 0, 3, 0);
        step("mret",    VALID, 32'h400, 0, 1, JUMP, 32'h300, 32'h300, 11, 0, 4, 0);
        step("mret_dn", BUBBLE, 0, 0, 0, READY, 0, 32'h300, 11, 0, 4, 0);

        // EBREAK reports its own PC in mtval
        step("eb_jump", EBREAK, 32'h500, 32'h99, 0,
             JUMP, 32'h8000, 32'h500, 3, 32'h500, 4, 1);
        step("eb_hold", BUBBLE, 0, 0, 0, STALL, 0, 32'h500, 3, 32'h500, 4, 0);
        step("eb_idle", BUBBLE, 0, 0, 0, READY, 0, 32'h500, 3, 32'h500, 4, 0);

        // Undefined status -> illegal; later faults ignored outside IDLE
        step("undef",   forwards_t'(4'hF), 32'h40, 32'h77, 0,
             JUMP, 32'h8000, 32'h40, 2, 32'h77, 4, 1);
        step("ign_jmp", STORE_FAULT, 32'h999, 32'h555, 0,
             STALL, 0, 32'h40, 2, 32'h77, 4, 0);
        step("ign_hld", STORE_FAULT, 32'h999, 32'h555, 0,
             READY, 0, 32'h40, 2, 32'h77, 4, 0);

        // MRET to 0x40; a VALID during RET_JUMP is not counted
        step("mret2",   VALID, 32'h600, 0, 1, JUMP, 32'h40, 32'h40, 2, 32'h77, 5, 0);
        step("ign_ret", VALID, 32'h604, 0, 0, READY, 0, 32'h40, 2, 32'h77, 5, 0);

        // 64-bit wrap of minstret
        wb_status = BUBBLE;
        force dut.r_minstret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_minstret;
        #1;
        cmp("preload", "minstret", minstret, 64'hFFFF_FFFF_FFFF_FFFF);
        step("wrap",  VALID, 32'h608, 0, 0, READY, 0, 32'h40, 2, 32'h77, 0, 0);
        step("after", VALID, 32'h60C, 0, 0, READY, 0, 32'h40, 2, 32'h77, 1, 0);

        // Reset in the middle of a trap
        step("lm_jump", LOAD_MISALIGNED, 32'h700, 32'h703, 0,
             JUMP, 32'h8000, 32'h700, 4, 32'h703, 1, 1);
        reset     = 1'b1;
        wb_status = BUBBLE;
        #1;
        expect_out("rst_async", READY, 0, 0, 0, 0, 0, 0);
        pop_check();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_out("rst_release", READY, 0, 0, 0, 0, 0, 0);
        pop_check();
        @(negedge clk);
        step("post_rst", BUBBLE, 0, 0, 0, READY, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_trap_unit
`default_nettype wire

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have no parameters; XLEN fixed at 32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 wb_status  input  4 (pipeline_status::forwards_t)  status of the instruction leaving writeback.
REQ-005 wb_pc  input  32  PC of that instruction.
REQ-006 wb_tval  input  32  faulting address or instruction bits from the pipeline.
REQ-007 wb_mret  input  1  instruction is MRET; meaningful only when wb_status==VALID.
REQ-008 mtvec  input  32  trap vector base from CSR file.
REQ-009 pipe_ctrl  output  2 (pipeline_status::backwards_t)  command broadcast back to all stages.
REQ-010 redirect_pc  output  32  fetch target; meaningful only while pipe_ctrl==JUMP.
REQ-011 mepc, mcause, mtval  output  32 each  trap CSR values.
REQ-012 minstret  output  64  retired-instruction count.
REQ-013 trap_taken  output  1  one-cycle pulse on trap capture.

Function
REQ-014 FSM states SHALL be IDLE, TRAP_JUMP, TRAP_HOLD, RET_JUMP.
REQ-015 pipe_ctrl SHALL be READY in IDLE, JUMP in TRAP_JUMP and RET_JUMP, and STALL in TRAP_HOLD.
REQ-016 In IDLE, wb_status==BUBBLE SHALL cause no state change.
REQ-017 In IDLE, wb_status==VALID with wb_mret=0 SHALL increment minstret by 1, with 64-bit wrap from all-ones to 0.
REQ-018 In IDLE, wb_status==VALID with wb_mret=1 SHALL increment minstret and enter RET_JUMP.
REQ-019 In IDLE, any other status SHALL capture mepc=wb_pc, mcause, and mtval, pulse trap_taken, enter TRAP_JUMP, and leave minstret unchanged.
REQ-020 mcause mapping SHALL be:
- FETCH_MISALIGNED=0, FETCH_FAULT=1, ILLEGAL_INSTRUCTION=2, EBREAK=3
- LOAD_MISALIGNED=4, LOAD_FAULT=5, STORE_MISALIGNED=6, STORE_FAULT=7, ECALL=11
- undefined encodings 11..15 SHALL map to 2 (illegal instruction).
REQ-021 mtval SHALL be 0 for ECALL, wb_pc for EBREAK, and wb_tval otherwise.
REQ-022 In TRAP_JUMP, redirect_pc SHALL be {mtvec[31:2],2'b00}; the FSM SHALL advance to TRAP_HOLD after 1 cycle.
REQ-023 TRAP_HOLD SHALL last exactly 1 cycle and then return to IDLE.
REQ-024 In RET_JUMP, redirect_pc SHALL equal mepc; the FSM SHALL return to IDLE after 1 cycle.
REQ-025 Outside IDLE, wb_status and wb_mret SHALL be ignored: no counting, no capture.
REQ-026 redirect_pc SHALL be 0 whenever pipe_ctrl!=JUMP.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from wb_* to pipe_ctrl.

Reset
REQ-028 Reset SHALL force IDLE, pipe_ctrl=READY, redirect_pc=0, mepc=mcause=mtval=0, minstret=0, and trap_taken=0.
REQ-029 Reset asserted mid-trap (any state) SHALL abort the trap; no JUMP SHALL follow deassertion.

Structure
REQ-030 The mcause code enum trap_cause_t (4 bits) SHALL be added to package pipeline_status; the FSM state enum SHALL be local to trap_unit.
REQ-031 The forwards_t-to-cause/tval mapping SHALL be a combinational sub-module named trap_cause_encode.

Verification
REQ-032 Three VALID at pc 0x100/0x104/0x108 -> minstret=3 and pipe_ctrl READY throughout.
REQ-033 LOAD_FAULT, pc=0x200, tval=0xDEAD0000, mtvec=0x8001 -> trap_taken pulse; next cycle JUMP to 0x8000 with mepc=0x200, mcause=5, mtval=0xDEAD0000; then STALL 1 cycle; then READY.
REQ-034 ECALL at pc 0x300, then MRET (VALID, wb_mret=1) -> mcause=11, mtval=0; RET_JUMP with redirect_pc=0x300; minstret +1 for the MRET only.
REQ-035 Status 4'hF at pc 0x40 -> mcause=2; wb_status held at STORE_FAULT during TRAP_JUMP/TRAP_HOLD is ignored (mcause remains 2).
REQ-036 minstret preloaded to all-ones via 2^64-1 VALIDs (forced) plus one VALID -> minstret=0.
REQ-037 Reset pulsed during TRAP_JUMP -> outputs clear immediately; pipe_ctrl READY after deassertion.
